// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator for RGB444 raster streams.
// Two line buffers plus a 3-column tap per row; borders replicate edge pixels.
module window3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    input  logic                 sof,
    output logic                 pix_ready,
    output logic [9*PIX_W-1:0]   color_data,
    output logic                 win_valid,
    output logic [9:0]           win_x,
    output logic [8:0]           win_y,
    output logic                 frame_done
);

    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = $clog2(IMG_H + 2);
    localparam int CYW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // input raster position of the next incoming pixel
    logic [XW-1:0]  r_ix;
    logic [YW-1:0]  r_iy;
    // centre of the next window to be emitted
    logic [XW-1:0]  r_cx;
    logic [CYW-1:0] r_cy;

    logic [PIX_W-1:0] r_lb0 [IMG_W];
    logic [PIX_W-1:0] r_lb1 [IMG_W];

    // two older columns per row; the newest column comes straight from the read
    logic [PIX_W-1:0] r_t0, r_t1;
    logic [PIX_W-1:0] r_m0, r_m1;
    logic [PIX_W-1:0] r_b0, r_b1;

    logic w_live;
    logic w_virt;
    logic w_accept;
    logic w_restart;
    logic w_evt;
    logic w_emit;
    logic w_last_in;
    logic w_past_fill;
    logic w_flush_end;

    logic [XW-1:0]    w_px;
    logic [YW-1:0]    w_py;
    logic [PIX_W-1:0] w_pin;
    logic [PIX_W-1:0] w_tn, w_mn, w_bn;

    logic w_cx_lo, w_cx_hi, w_cy_lo, w_cy_hi;

    logic [PIX_W-1:0] w_t_l, w_t_r;
    logic [PIX_W-1:0] w_m_l, w_m_r;
    logic [PIX_W-1:0] w_b_l, w_b_r;
    logic [PIX_W-1:0] w_u_c, w_u_l, w_u_r;
    logic [PIX_W-1:0] w_d_c, w_d_l, w_d_r;
    logic [9*PIX_W-1:0] w_win;

    // event bookkeeping: a real pixel of the frame or an injected virtual one
    assign w_accept    = pix_valid & pix_ready;
    assign w_restart   = w_accept & sof;
    assign w_evt       = w_restart | (w_accept & w_live) | w_virt;
    assign w_px        = w_restart ? '0 : r_ix;
    assign w_py        = w_restart ? '0 : r_iy;
    assign w_pin       = w_virt ? '0 : pix_in;
    assign w_last_in   = (w_px == XW'(IMG_W - 1))
                       && (w_py == YW'(IMG_H - 1));
    assign w_past_fill = (w_py > YW'(1))
                       || ((w_py == YW'(1)) && (w_px != '0));
    assign w_flush_end = (w_px == '0) && (w_py == YW'(IMG_H + 1));
    assign w_emit      = w_evt & ~w_restart & w_past_fill;

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_restart) w_state_nxt = S_FILL;
            end
            S_FILL, S_RUN: begin
                if (w_restart)        w_state_nxt = S_FILL;
                else if (w_accept) begin
                    if (w_last_in)        w_state_nxt = S_FLUSH;
                    else if (w_past_fill) w_state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                if (w_flush_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state-decoded outputs: ready, live frame, virtual injection
    always_comb begin
        pix_ready = 1'b1;
        w_live    = 1'b0;
        w_virt    = 1'b0;
        case (r_state)
            S_FILL, S_RUN: w_live = 1'b1;
            S_FLUSH: begin
                pix_ready = 1'b0;
                w_virt    = 1'b1;
            end
            default: ;
        endcase
    end

    // input raster counter, wraps W-1 -> 0 and bumps the row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ix <= '0;
            r_iy <= '0;
        end else if (w_evt) begin
            if (w_px == XW'(IMG_W - 1)) begin
                r_ix <= '0;
                r_iy <= w_py + YW'(1);
            end else begin
                r_ix <= w_px + XW'(1);
                r_iy <= w_py;
            end
        end
    end

    // centre counter advances once per emitted window
    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_emit) begin
            if (r_cx == XW'(IMG_W - 1)) begin
                r_cx <= '0;
                r_cy <= w_cy_hi ? '0 : r_cy + CYW'(1);
            end else begin
                r_cx <= r_cx + XW'(1);
            end
        end
    end

    assign w_tn = r_lb1[w_px];
    assign w_mn = r_lb0[w_px];
    assign w_bn = w_pin;

    // line buffers roll down one row, column taps shift one column
    always_ff @(posedge clk) begin
        if (w_evt) begin
            r_lb0[w_px] <= w_pin;
            r_lb1[w_px] <= w_mn;
            r_t0 <= w_tn;
            r_t1 <= r_t0;
            r_m0 <= w_mn;
            r_m1 <= r_m0;
            r_b0 <= w_bn;
            r_b1 <= r_b0;
        end
    end

    assign w_cx_lo = (r_cx == '0);
    assign w_cx_hi = (r_cx == XW'(IMG_W - 1));
    assign w_cy_lo = (r_cy == '0);
    assign w_cy_hi = (r_cy == CYW'(IMG_H - 1));

    // centre column is always the middle tap; neighbours clamp at edges
    assign w_t_l = w_cx_lo ? r_t0 : r_t1;
    assign w_t_r = w_cx_hi ? r_t0 : w_tn;
    assign w_m_l = w_cx_lo ? r_m0 : r_m1;
    assign w_m_r = w_cx_hi ? r_m0 : w_mn;
    assign w_b_l = w_cx_lo ? r_b0 : r_b1;
    assign w_b_r = w_cx_hi ? r_b0 : w_bn;

    assign w_u_c = w_cy_lo ? r_m0  : r_t0;
    assign w_u_l = w_cy_lo ? w_m_l : w_t_l;
    assign w_u_r = w_cy_lo ? w_m_r : w_t_r;
    assign w_d_c = w_cy_hi ? r_m0  : r_b0;
    assign w_d_l = w_cy_hi ? w_m_l : w_b_l;
    assign w_d_r = w_cy_hi ? w_m_r : w_b_r;

    assign w_win = {r_m0, w_m_l, w_m_r,
                    w_u_c, w_d_c,
                    w_u_l, w_u_r,
                    w_d_l, w_d_r};

    // registered window output
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            color_data <= '0;
            win_x      <= '0;
            win_y      <= '0;
        end else begin
            win_valid  <= w_emit;
            frame_done <= w_emit & w_cx_hi & w_cy_hi;
            if (w_emit) begin
                color_data <= w_win;
                win_x      <= 10'(r_cx);
                win_y      <= 9'(r_cy);
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen at 4x3.
// Windows are checked against a clamp-neighbourhood model and hand values.
module tb_window3x3_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  pix_in;
    logic         pix_valid;
    logic         sof;
    logic         pix_ready;
    logic [107:0] color_data;
    logic         win_valid;
    logic [9:0]   win_x;
    logic [8:0]   win_y;
    logic         frame_done;

    int n_run  = 0;
    int n_fail = 0;

    int cyc = 0;
    int win_cnt = 0;
    int fd_cnt = 0;
    int first_cyc = -1;
    int acc5 = -2;
    logic [107:0] first_data;
    logic [107:0] last_data;
    logic xfer_q = 1'b0;
    logic flush_q = 1'b0;
    logic [11:0] pv [12];

    window3x3_gen #(.IMG_W(4), .IMG_H(3), .PIX_W(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .pix_ready  (pix_ready),
        .color_data (color_data),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [107:0] got,
                       input logic [107:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [107:0] mwin(input int cx, input int cy);
        int xl, xr, yu, yd;
        xl = (cx == 0) ? 0 : cx - 1;
        xr = (cx == 3) ? 3 : cx + 1;
        yu = (cy == 0) ? 0 : cy - 1;
        yd = (cy == 2) ? 2 : cy + 1;
        return {pv[cy*4+cx], pv[cy*4+xl], pv[cy*4+xr],
                pv[yu*4+cx], pv[yd*4+cx],
                pv[yu*4+xl], pv[yu*4+xr],
                pv[yd*4+xl], pv[yd*4+xr]};
    endfunction

    function automatic logic [107:0] pk(input int a, input int b,
        input int c, input int d, input int e, input int f,
        input int g, input int h, input int k);
        return {12'(a), 12'(b), 12'(c), 12'(d), 12'(e),
                12'(f), 12'(g), 12'(h), 12'(k)};
    endfunction

    task automatic load(input int base);
        for (int i = 0; i < 12; i++) pv[i] = 12'(base + i + 1);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        xfer_q = pix_valid & pix_ready & ~reset;
        flush_q = ~pix_ready;
    end

    always @(negedge clk) begin : mon
        int n;
        if (win_valid) begin
            n = win_cnt;
            chk("win_src", 108'(xfer_q | flush_q), 108'(1));
            chk("win_x", 108'(win_x), 108'(n % 4));
            chk("win_y", 108'(win_y), 108'((n / 4) % 3));
            chk("win_data", color_data, mwin(n % 4, (n / 4) % 3));
            chk("frame_done", 108'(frame_done), 108'(n == 11));
            if (n == 0) begin
                first_cyc = cyc;
                first_data = color_data;
            end
            if (frame_done) begin
                last_data = color_data;
                fd_cnt++;
            end
            win_cnt++;
        end
    end

    task automatic send(input int base, input int n, input int gap);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (pix_ready && ($urandom_range(99) >= gap)) begin
                pix_valid = 1'b1;
                pix_in = 12'(base + i + 1);
                sof = (i == 0);
                if (i == 5) acc5 = cyc + 1;
                i++;
            end else begin
                pix_valid = 1'b0;
                sof = 1'b0;
            end
        end
        if (i < n) chk("send_timeout", 108'(i), 108'(n));
        @(negedge clk);
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic flush_count(output int nlow);
        nlow = 0;
        for (int k = 0; k < 20; k++) begin
            if (pix_ready) break;
            nlow++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wv"}, 108'(win_valid), 108'(0));
        chk({tag, "_cd"}, color_data, 108'(0));
        chk({tag, "_wx"}, 108'(win_x), 108'(0));
        chk({tag, "_wy"}, 108'(win_y), 108'(0));
        chk({tag, "_fd"}, 108'(frame_done), 108'(0));
        chk({tag, "_rdy"}, 108'(pix_ready), 108'(1));
    endtask

    task automatic full_frame(input string tag, input int gap);
        int nlow;
        win_cnt = 0;
        fd_cnt = 0;
        send(0, 12, gap);
        flush_count(nlow);
        chk({tag, "_flush_len"}, 108'(nlow), 108'(5));
        repeat (3) @(negedge clk);
        chk({tag, "_nwin"}, 108'(win_cnt), 108'(12));
        chk({tag, "_nfd"}, 108'(fd_cnt), 108'(1));
        chk({tag, "_last"}, last_data, pk(12, 11, 12, 8, 12, 7, 8, 11, 12));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int nlow;
        reset = 1'b1;
        pix_in = '0;
        pix_valid = 1'b0;
        sof = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        reset = 1'b0;

        // 1+2: clean frame, continuous valid
        full_frame("t2", 0);
        chk("t1_first_cyc", 108'(first_cyc), 108'(acc5));
        chk("t1_first", first_data, pk(1, 1, 2, 1, 5, 1, 2, 5, 6));

        // 3: random gaps on the input
        full_frame("t3", 50);

        // 4: sof re-asserted at index 7
        win_cnt = 0;
        fd_cnt = 0;
        send(0, 7, 0);
        repeat (2) @(negedge clk);
        chk("t4_old_nwin", 108'(win_cnt), 108'(2));
        load(100);
        win_cnt = 0;
        send(100, 12, 0);
        flush_count(nlow);
        chk("t4_flush_len", 108'(nlow), 108'(5));
        repeat (3) @(negedge clk);
        chk("t4_nwin", 108'(win_cnt), 108'(12));
        chk("t4_nfd", 108'(fd_cnt), 108'(1));
        chk("t4_first", first_data,
            pk(101, 101, 102, 101, 105, 101, 102, 105, 106));
        chk("t4_last", last_data,
            pk(112, 111, 112, 108, 112, 107, 108, 111, 112));

        // 5: reset at index 9, then a clean frame
        load(0);
        win_cnt = 0;
        fd_cnt = 0;
        send(0, 9, 0);
        reset = 1'b1;
        pix_valid = 1'b1;
        pix_in = 12'd10;
        @(negedge clk);
        reset = 1'b0;
        pix_valid = 1'b0;
        check_idle_outputs("t5_rst");
        chk("t5_pre_nwin", 108'(win_cnt), 108'(4));
        chk("t5_pre_nfd", 108'(fd_cnt), 108'(0));
        full_frame("t5", 0);

        // 6: pixels without sof while idle
        win_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_rdy", 108'(pix_ready), 108'(1));
            pix_valid = 1'b1;
            sof = 1'b0;
            pix_in = 12'(i + 50);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rdy_end", 108'(pix_ready), 108'(1));
        chk("t6_nwin", 108'(win_cnt), 108'(0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
